// File: rtl/level_hold_transmitter_if.sv
// Transmit handshake bundle: the source offers a level with tx_valid/tx_bit and
// the transmitter answers with tx_ready.
interface level_hold_transmitter_if;
  logic tx_valid;
  logic tx_bit;
  logic tx_ready;

  modport master (
    output tx_valid,
    output tx_bit,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_bit,
    output tx_ready
  );
endinterface

// File: rtl/level_hold_transmitter.sv
// Single-wire level transmitter: holds every accepted level on line_out for exactly
// HoldSamples sample_clk cycles, with a one-deep pending slot for gap-free streaming.
module level_hold_transmitter #(
  parameter int unsigned HoldSamples = 24,  // legal range >= 2
  parameter bit          IdleLevel   = 1'b0
) (
  input  logic                     sample_clk,
  input  logic                     reset,
  level_hold_transmitter_if.slave  tx,
  output logic                     line_out,
  output logic                     busy,
  output logic                     hold_done
);

  localparam int unsigned CntW = $clog2(HoldSamples);
  localparam logic [CntW-1:0] CntLoad = CntW'(HoldSamples - 1);

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] count_q;
  logic            pending_valid_q;
  logic            pending_bit_q;
  logic            accept;
  logic            terminal;

  // Ready stays high at the terminal edge when the slot is empty, enabling bypass.
  assign tx.tx_ready = ~pending_valid_q;
  assign accept      = tx.tx_valid & ~pending_valid_q;
  assign terminal    = (count_q == '0);

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      count_q         <= '0;
      pending_valid_q <= 1'b0;
      pending_bit_q   <= 1'b0;
      line_out        <= IdleLevel;
      busy            <= 1'b0;
      hold_done       <= 1'b0;
    end else begin
      hold_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            line_out <= tx.tx_bit;
            count_q  <= CntLoad;
            busy     <= 1'b1;
            state_q  <= StHold;
          end
        end
        StHold: begin
          if (!terminal) begin
            count_q <= count_q - CntW'(1);
            if (accept) begin
              pending_bit_q   <= tx.tx_bit;
              pending_valid_q <= 1'b1;
            end
          end else begin
            hold_done <= 1'b1;
            if (pending_valid_q) begin
              line_out        <= pending_bit_q;
              pending_valid_q <= 1'b0;
              count_q         <= CntLoad;
            end else if (accept) begin
              line_out <= tx.tx_bit;
              count_q  <= CntLoad;
            end else begin
              // Line keeps its last level; only reset returns it to IdleLevel.
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
